// File: rtl/noise_gate_expander_if.sv
// Audio sample stream for the noise gate: input strobe and sample in, gated sample and strobe out.
interface noise_gate_expander_if;
    logic               sample_valid;
    logic signed [23:0] audio_in;
    logic               out_valid;
    logic signed [23:0] audio_out;

    modport master (output sample_valid, output audio_in, input out_valid, input audio_out);
    modport slave  (input sample_valid, input audio_in, output out_valid, output audio_out);
endinterface

// File: rtl/noise_gate_expander.sv
// Downward expander / noise gate: peak envelope, hysteretic gate FSM with hold, ramped Q1.15 gain.
// Optional GATE_LOOKAHEAD_EN delays the gained audio by LOOKAHEAD strobes so the gate opens ahead of transients.
module noise_gate_expander #(
    parameter int DECAY_SHIFT = 6,
    parameter int LOOKAHEAD   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    noise_gate_expander_if.slave  aif,
    input  logic [23:0]           open_threshold,
    input  logic [23:0]           close_threshold,
    input  logic [15:0]           hold_samples,
    input  logic [15:0]           attack_step,
    input  logic [15:0]           release_step,
    input  logic [15:0]           floor_gain,
    output logic [2:0]            gate_state,
    output logic                  gate_open
);
    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam logic [COEF_W:0] UNITY = 17'h08000;

    if (LOOKAHEAD < 1 || LOOKAHEAD > 16) begin : g_bad_lookahead
        $error("LOOKAHEAD must be in 1..16");
    end

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        if (x == 24'sh800000)
            abs_sat = 24'h7FFFFF;
        else if (x[DATA_W-1])
            abs_sat = $unsigned(-x);
        else
            abs_sat = $unsigned(x);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat24(input logic signed [41:0] x);
        if (x > 42'sh7FFFFF)
            sat24 = 24'sh7FFFFF;
        else if (x < -42'sh800000)
            sat24 = 24'sh800000;
        else
            sat24 = x[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_gain(input logic signed [DATA_W-1:0] s,
                                                            input logic [COEF_W:0] g);
        logic signed [41:0] prod;
        prod = 42'(s) * 42'($signed({1'b0, g}));
        apply_gain = sat24(prod >>> 15);
    endfunction

    logic [DATA_W-1:0]        env_q, env_d;
    logic [COEF_W:0]          gain_q, gain_d;
    state_e                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic signed [DATA_W-1:0] audio_out_q, audio_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     gate_open_q, gate_open_d;

    logic [DATA_W-1:0]        in_abs, env_decay, env_nx;
    logic [COEF_W:0]          floor_c, gain_up, gain_dn, gain_rise, gain_fall;
    logic signed [DATA_W-1:0] gain_src;

`ifdef GATE_LOOKAHEAD_EN
    localparam int PW = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;
    logic signed [DATA_W-1:0] dly_q [LOOKAHEAD];
    logic [PW-1:0]            ptr_q, ptr_d;

    // The slot at the write pointer holds the sample from LOOKAHEAD strobes ago.
    assign gain_src = dly_q[ptr_q];
    assign ptr_d    = !aif.sample_valid ? ptr_q :
                      (ptr_q == PW'(LOOKAHEAD - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LOOKAHEAD; i++) dly_q[i] <= '0;
            ptr_q <= '0;
        end else begin
            if (aif.sample_valid) dly_q[ptr_q] <= aif.audio_in;
            ptr_q <= ptr_d;
        end
    end
`else
    assign gain_src = aif.audio_in;
`endif

    assign in_abs    = abs_sat(aif.audio_in);
    assign env_decay = env_q - (env_q >> DECAY_SHIFT);
    assign env_nx    = (in_abs > env_decay) ? in_abs : env_decay;
    assign floor_c   = (floor_gain > 16'h8000) ? UNITY : {1'b0, floor_gain};

    // 17 bits cover 0x8000 + 0xFFFF; the fall path clamps at zero before the floor.
    assign gain_up   = gain_q + {1'b0, attack_step};
    assign gain_rise = (gain_up >= UNITY) ? UNITY : gain_up;
    assign gain_dn   = ({1'b0, release_step} >= gain_q) ? '0 : gain_q - {1'b0, release_step};
    assign gain_fall = (gain_dn < floor_c) ? floor_c : gain_dn;

    always_comb begin
        env_d       = env_q;
        gain_d      = gain_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        audio_out_d = audio_out_q;
        out_valid_d = aif.sample_valid;
        gate_open_d = gate_open_q;
        if (aif.sample_valid) begin
            env_d = env_nx;
            if (!enable) begin
                state_d = ST_OPEN;
                gain_d  = UNITY;
            end else begin
                case (state_q)
                    ST_CLOSED: begin
                        gain_d = floor_c;
                        if (env_nx >= open_threshold) state_d = ST_ATTACK;
                    end
                    ST_ATTACK: begin
                        gain_d = gain_rise;
                        if (gain_rise == UNITY) state_d = ST_OPEN;
                    end
                    ST_OPEN: begin
                        gain_d = UNITY;
                        if (env_nx < close_threshold) begin
                            state_d = ST_HOLD;
                            cnt_d   = hold_samples;
                        end
                    end
                    ST_HOLD: begin
                        if (env_nx >= open_threshold) state_d = ST_OPEN;
                        else if (cnt_q == 16'd0)      state_d = ST_RELEASE;
                        else                          cnt_d   = cnt_q - 16'd1;
                    end
                    ST_RELEASE: begin
                        // A re-trigger keeps the current gain so the attack resumes from it.
                        if (env_nx >= open_threshold) begin
                            state_d = ST_ATTACK;
                        end else begin
                            gain_d = gain_fall;
                            if (gain_fall == floor_c) state_d = ST_CLOSED;
                        end
                    end
                    default: begin
                        state_d = ST_OPEN;
                        gain_d  = UNITY;
                    end
                endcase
            end
            gate_open_d = (state_d == ST_ATTACK) || (state_d == ST_OPEN) || (state_d == ST_HOLD);
            audio_out_d = enable ? apply_gain(gain_src, gain_d) : aif.audio_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            env_q       <= '0;
            gain_q      <= UNITY;
            state_q     <= ST_OPEN;
            cnt_q       <= '0;
            audio_out_q <= '0;
            out_valid_q <= 1'b0;
            gate_open_q <= 1'b1;
        end else begin
            env_q       <= env_d;
            gain_q      <= gain_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            audio_out_q <= audio_out_d;
            out_valid_q <= out_valid_d;
            gate_open_q <= gate_open_d;
        end
    end

    assign aif.audio_out = audio_out_q;
    assign aif.out_valid = out_valid_q;
    assign gate_state    = state_q;
    assign gate_open     = gate_open_q;
endmodule

// File: tb/tb_noise_gate_expander.sv
// Randomized bench for noise_gate_expander against a per-strobe integer reference model.
module tb_noise_gate_expander;
    localparam int DS = 6;
    localparam int LA = 4;
    localparam int S_C = 0, S_A = 1, S_O = 2, S_H = 3, S_R = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [23:0] open_threshold = 24'h010000;
    logic [23:0] close_threshold = 24'h008000;
    logic [15:0] hold_samples = 16'd0;
    logic [15:0] attack_step = 16'h2000;
    logic [15:0] release_step = 16'h2000;
    logic [15:0] floor_gain = 16'h0000;
    logic [2:0]  gate_state;
    logic        gate_open;

    noise_gate_expander_if aif ();

    noise_gate_expander #(.DECAY_SHIFT(DS), .LOOKAHEAD(LA)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .aif(aif.slave),
        .open_threshold(open_threshold), .close_threshold(close_threshold),
        .hold_samples(hold_samples), .attack_step(attack_step),
        .release_step(release_step), .floor_gain(floor_gain),
        .gate_state(gate_state), .gate_open(gate_open)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    int m_env, m_gain, m_state, m_cnt, m_out;
    int m_dly[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_env = 0; m_gain = 32'h8000; m_state = S_O; m_cnt = 0; m_out = 0;
        m_dly.delete();
        for (int i = 0; i < LA; i++) m_dly.push_back(0);
    endtask

    // Reference: one audio sample through the gate, straight from the rules.
    task automatic m_strobe(input int s);
        int a, dec, e, fl, d, ot, ct;
        longint p;
        ot = int'(open_threshold);
        ct = int'(close_threshold);
        a = (s < 0) ? -s : s;
        if (a > 32'h7FFFFF) a = 32'h7FFFFF;
        dec = m_env - (m_env >> DS);
        e = (a > dec) ? a : dec;
        m_env = e;
        fl = (int'(floor_gain) > 32'h8000) ? 32'h8000 : int'(floor_gain);
`ifdef GATE_LOOKAHEAD_EN
        m_dly.push_back(s);
        d = m_dly.pop_front();
`else
        d = s;
`endif
        if (!enable) begin
            m_state = S_O; m_gain = 32'h8000; m_out = s;
            return;
        end
        case (m_state)
            S_C: begin
                m_gain = fl;
                if (e >= ot) m_state = S_A;
            end
            S_A: begin
                m_gain = m_gain + int'(attack_step);
                if (m_gain >= 32'h8000) begin m_gain = 32'h8000; m_state = S_O; end
            end
            S_O: begin
                m_gain = 32'h8000;
                if (e < ct) begin m_state = S_H; m_cnt = int'(hold_samples); end
            end
            S_H: begin
                if (e >= ot) m_state = S_O;
                else if (m_cnt == 0) m_state = S_R;
                else m_cnt--;
            end
            default: begin
                if (e >= ot) m_state = S_A;
                else begin
                    m_gain = m_gain - int'(release_step);
                    if (m_gain <= fl) begin m_gain = fl; m_state = S_C; end
                end
            end
        endcase
        p = (longint'(d) * longint'(m_gain)) >>> 15;
        if (p > 64'sh7FFFFF) p = 64'sh7FFFFF;
        if (p < -64'sh800000) p = -64'sh800000;
        m_out = int'(p);
    endtask

    // Drive one cycle (strobe or idle) at the falling edge, check the registered result one cycle later.
    task automatic step(input bit v, input int s);
        logic signed [23:0] s24;
        s24 = s[23:0];
        aif.sample_valid = v;
        aif.audio_in = s24;
        if (v) m_strobe(s);
        @(negedge clk);
        chk("out_valid", int'(aif.out_valid), int'(v));
        chk("audio_out", int'(aif.audio_out), m_out);
        if (v) begin
            chk("gate_state", int'(gate_state), m_state);
            chk("gate_open", int'(gate_open), int'(m_state == S_A || m_state == S_O || m_state == S_H));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        aif.sample_valid = 1'b0;
        m_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(aif.out_valid), 0);
        chk("rst_audio_out", int'(aif.audio_out), 0);
        chk("rst_state", int'(gate_state), S_O);
        chk("rst_gate_open", int'(gate_open), 1);
        rst_n = 1'b1;
    endtask

    function automatic int rnd_sample();
        logic signed [23:0] r;
        r = 24'($urandom);
        case ($urandom_range(0, 3))
            0: return int'(r) >>> 10;
            1: return int'(r) >>> 5;
            2: return int'(r);
            default: return 0;
        endcase
    endfunction

    initial begin
        aif.sample_valid = 1'b0;
        aif.audio_in = '0;
        @(negedge clk);
        do_reset();

        // Quiet input closes the gate: OPEN -> HOLD -> RELEASE (4 steps) -> CLOSED.
        for (int i = 0; i < 20; i++) step(1'b1, 32'h100);
        chk("closed_after_quiet", int'(gate_state), S_C);
        chk("closed_out_zero", int'(aif.audio_out), 0);

        // Loud input opens with a 4-step attack.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h20000);
        chk("open_after_attack", int'(gate_state), S_O);
        chk("open_unity_out", int'(aif.audio_out), 32'h20000);

        // Hold window, then a re-trigger during HOLD.
        hold_samples = 16'd3;
        for (int i = 0; i < 92; i++) step(1'b1, 0);
        step(1'b1, 32'h20000);
        for (int i = 0; i < 120; i++) step(1'b1, 0);
        release_step = 16'h1000;
        for (int i = 0; i < 4; i++) step(i % 2 == 0, 0);
        step(1'b1, 32'h7FFFFF);
        step(1'b1, -32'sh800000);
        for (int i = 0; i < 4; i++) step(1'b1, -32'sh800000);
        chk("neg_full_scale", int'(aif.audio_out), -32'sh800000);

        // Bypass while closed, then reset mid-attack.
        for (int i = 0; i < 400; i++) step(1'b1, 0);
        enable = 1'b0;
        step(1'b1, 32'h123456);
        chk("bypass_out", int'(aif.audio_out), 32'h123456);
        chk("bypass_state", int'(gate_state), S_O);
        enable = 1'b1;
        for (int i = 0; i < 400; i++) step(1'b1, 0);
        attack_step = 16'h0800;
        step(1'b1, 32'h400000);
        step(1'b1, 32'h400000);
        chk("mid_attack", int'(gate_state), S_A);
        do_reset();

`ifdef GATE_LOOKAHEAD_EN
        attack_step = 16'h2000;
        for (int i = 0; i < 30; i++) step(1'b1, 32'h100);
        step(1'b1, 32'h400000);
        for (int i = 0; i < 6; i++) step(1'b1, 0);
`endif

        // Randomized traffic with config changes, idle gaps, bypass toggles and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                open_threshold  = 24'($urandom_range(32'h1000, 32'h200000));
                close_threshold = 24'($urandom_range(0, int'(open_threshold)));
                hold_samples    = 16'($urandom_range(0, 5));
                attack_step     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 32'h4000));
                release_step    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 32'h4000));
                floor_gain      = 16'($urandom_range(0, 32'h9000));
            end
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 999) == 0) do_reset();
            step(1'b1, rnd_sample());
            for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 0);
        end

        aif.sample_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
